// File: rtl/mips_reg_file.sv
// MIPS-I architectural register file: 31 stored GPRs ($0 hardwired to zero) plus HI/LO.
// Two combinational read ports with same-cycle write-through bypass from writeback.
module mips_reg_file (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reg_write_en,
   input  logic [4:0]  reg_write_addr,
   input  logic [31:0] reg_write_data,
   input  logic [4:0]  read_addr_a,
   input  logic [4:0]  read_addr_b,
   output logic [31:0] read_data_a,
   output logic [31:0] read_data_b,
   input  logic        hi_write_en,
   input  logic        lo_write_en,
   input  logic [31:0] hi_write_data,
   input  logic [31:0] lo_write_data,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] register_v0
);

   logic [31:0] regs_q [1:31];
   logic [31:0] regs_d [1:31];
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        wr_live;

   // A write to $0 is a no-op; the enable is tested first so X address/data are inert when idle.
   assign wr_live = reg_write_en && (reg_write_addr != 5'd0);

   always_comb begin
      regs_d = regs_q;
      if (wr_live) regs_d[reg_write_addr] = reg_write_data;
      hi_d = hi_write_en ? hi_write_data : hi_q;
      lo_d = lo_write_en ? lo_write_data : lo_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) regs_q[i] <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         regs_q <= regs_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] addr);
      logic [31:0] val;
      val = '0;
      if (addr != 5'd0) begin
         // Bypass lets decode see the value writeback commits at the end of this cycle.
         if (rst_n && wr_live && (addr == reg_write_addr)) val = reg_write_data;
         else                                               val = regs_q[addr];
      end
      return val;
   endfunction

   assign read_data_a = read_port(read_addr_a);
   assign read_data_b = read_port(read_addr_b);
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign register_v0 = regs_q[2];

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed self-checking bench for mips_reg_file with hand-computed expectations.
module tb_mips_reg_file;

   logic        clk;
   logic        rst_n;
   logic        reg_write_en;
   logic [4:0]  reg_write_addr;
   logic [31:0] reg_write_data;
   logic [4:0]  read_addr_a;
   logic [4:0]  read_addr_b;
   logic [31:0] read_data_a;
   logic [31:0] read_data_b;
   logic        hi_write_en;
   logic        lo_write_en;
   logic [31:0] hi_write_data;
   logic [31:0] lo_write_data;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic [31:0] register_v0;

   int total = 0;
   int bad   = 0;

   mips_reg_file dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .reg_write_en   (reg_write_en),
      .reg_write_addr (reg_write_addr),
      .reg_write_data (reg_write_data),
      .read_addr_a    (read_addr_a),
      .read_addr_b    (read_addr_b),
      .read_data_a    (read_data_a),
      .read_data_b    (read_data_b),
      .hi_write_en    (hi_write_en),
      .lo_write_en    (lo_write_en),
      .hi_write_data  (hi_write_data),
      .lo_write_data  (lo_write_data),
      .hi_out         (hi_out),
      .lo_out         (lo_out),
      .register_v0    (register_v0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] v;
      rst_n          = 1'b0;
      reg_write_en   = 1'b0;
      reg_write_addr = 5'd0;
      reg_write_data = 32'h0;
      read_addr_a    = 5'd5;
      read_addr_b    = 5'd2;
      hi_write_en    = 1'b0;
      lo_write_en    = 1'b0;
      hi_write_data  = 32'h0;
      lo_write_data  = 32'h0;
      #2;
      chk("rst_rda", read_data_a, 32'h0);
      chk("rst_rdb", read_data_b, 32'h0);
      chk("rst_hi",  hi_out, 32'h0);
      chk("rst_lo",  lo_out, 32'h0);
      chk("rst_v0",  register_v0, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Preload regs[5], regs[2] and HI, then assert reset between edges
      reg_write_en = 1'b1; reg_write_addr = 5'd5; reg_write_data = 32'hDEADBEEF;
      hi_write_en = 1'b1; hi_write_data = 32'h1;
      tick();
      hi_write_en = 1'b0;
      reg_write_addr = 5'd2; reg_write_data = 32'hCAFE0002;
      tick();
      reg_write_en = 1'b0;
      #1;
      chk("pre_r5", read_data_a, 32'hDEADBEEF);
      chk("pre_hi", hi_out, 32'h1);
      chk("pre_v0", register_v0, 32'hCAFE0002);
      rst_n = 1'b0;
      #1;
      chk("arst_r5", read_data_a, 32'h0);
      chk("arst_hi", hi_out, 32'h0);
      chk("arst_v0", register_v0, 32'h0);
      // Writes and bypass are dead while reset is held
      reg_write_en = 1'b1; reg_write_addr = 5'd5; reg_write_data = 32'h11111111;
      #1;
      chk("arst_nobyp", read_data_a, 32'h0);
      tick();
      reg_write_en = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("arst_nowrite", read_data_a, 32'h0);
      tick();

      // Link write to $31
      read_addr_a = 5'd31; read_addr_b = 5'd30;
      reg_write_en = 1'b1; reg_write_addr = 5'd31; reg_write_data = 32'hBFC00008;
      #1;
      chk("link_byp", read_data_a, 32'hBFC00008);
      tick();
      reg_write_en = 1'b0;
      #1;
      chk("link_r31", read_data_a, 32'hBFC00008);
      chk("link_r30", read_data_b, 32'h0);
      chk("link_v0",  register_v0, 32'h0);

      // $0 protection
      read_addr_a = 5'd0; read_addr_b = 5'd0;
      reg_write_en = 1'b1; reg_write_addr = 5'd0; reg_write_data = 32'h12345678;
      #1;
      chk("z_byp_a", read_data_a, 32'h0);
      chk("z_byp_b", read_data_b, 32'h0);
      tick();
      reg_write_en = 1'b0;
      #1;
      chk("z_post_a", read_data_a, 32'h0);
      chk("z_post_b", read_data_b, 32'h0);

      // Bypass over an existing value
      reg_write_en = 1'b1; reg_write_addr = 5'd8; reg_write_data = 32'hAAAA0000;
      tick();
      read_addr_b = 5'd8; read_addr_a = 5'd8;
      reg_write_data = 32'h5555FFFF;
      #1;
      chk("byp_b_pre", read_data_b, 32'h5555FFFF);
      chk("byp_a_pre", read_data_a, 32'h5555FFFF);
      tick();
      reg_write_en = 1'b0;
      #1;
      chk("byp_b_post", read_data_b, 32'h5555FFFF);
      read_addr_a = 5'd9;
      reg_write_en = 1'b1; reg_write_addr = 5'd9; reg_write_data = 32'h0BAD0BAD;
      #1;
      chk("byp_other", read_data_b, 32'h5555FFFF);
      tick();
      reg_write_en = 1'b0;

      // HI/LO simultaneous write, no bypass
      hi_write_en = 1'b1; hi_write_data = 32'h00000001;
      lo_write_en = 1'b1; lo_write_data = 32'hFFFFFFFE;
      #1;
      chk("hl_hi_pre", hi_out, 32'h0);
      chk("hl_lo_pre", lo_out, 32'h0);
      tick();
      hi_write_en = 1'b0; lo_write_en = 1'b0;
      hi_write_data = 32'h77777777; lo_write_data = 32'h66666666;
      #1;
      chk("hl_hi_post", hi_out, 32'h00000001);
      chk("hl_lo_post", lo_out, 32'hFFFFFFFE);
      chk("hl_gpr",     read_data_b, 32'h5555FFFF);
      tick();
      chk("hl_hi_hold", hi_out, 32'h00000001);
      lo_write_en = 1'b1;
      tick();
      lo_write_en = 1'b0;
      chk("hl_lo_only", lo_out, 32'h66666666);
      chk("hl_hi_keep", hi_out, 32'h00000001);

      // Idle X on write address/data must not disturb anything
      reg_write_addr = 'x; reg_write_data = 'x;
      read_addr_a = 5'd31;
      #1;
      chk("x_r31", read_data_a, 32'hBFC00008);
      chk("x_r8",  read_data_b, 32'h5555FFFF);
      tick();
      chk("x_r31_post", read_data_a, 32'hBFC00008);

      // Full sweep of indices 1..31
      reg_write_en = 1'b1;
      for (int i = 1; i < 32; i++) begin
         reg_write_addr = 5'(i);
         reg_write_data = 32'(i) * 32'h01010101;
         tick();
      end
      reg_write_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         read_addr_a = 5'(i);
         read_addr_b = 5'(31 - i);
         v = 32'(i) * 32'h01010101;
         #1;
         chk($sformatf("sweep_a%0d", i), read_data_a, v);
         chk($sformatf("sweep_b%0d", 31 - i), read_data_b, 32'(31 - i) * 32'h01010101);
      end
      read_addr_a = 5'd17; read_addr_b = 5'd17;
      #1;
      chk("same_idx", read_data_a, read_data_b === 32'h11111111 ? 32'h11111111 : 32'hFFFFFFFF);
      chk("sweep_v0", register_v0, 32'h02020202);
      chk("sweep_hi", hi_out, 32'h00000001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_reg_file.md
# mips_reg_file

Architectural register file for the MIPS-I core: 32 × 32-bit general-purpose registers plus the HI/LO pair. It sits directly downstream of the write-address link selector. That selector supplies the final destination index, already forced to 31 for JAL/BGEZAL/BLTZAL. This block commits the writeback on the clock edge and serves two combinational read ports to decode/execute. It also exports $v0 for the testbench harness.

## Interface

Parameters:
- none; widths fixed by the ISA (32 registers, 32-bit data).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reg_write_en  in  1  commit GPR write this cycle.
- reg_write_addr  in  5  destination index from the link selector.
- reg_write_data  in  32  writeback value (ALU result, load data, or PC+8 for links).
- read_addr_a  in  5  rs index.
- read_addr_b  in  5  rt index.
- read_data_a  out  32  value of rs.
- read_data_b  out  32  value of rt.
- hi_write_en  in  1  commit HI write.
- lo_write_en  in  1  commit LO write.
- hi_write_data  in  32  new HI.
- lo_write_data  in  32  new LO.
- hi_out  out  32  current HI.
- lo_out  out  32  current LO.
- register_v0  out  32  current $2, for harness result checking.

## Operation

- Storage: regs[1..31], hi, lo are flip-flops. $0 is not stored.
- Reset: rst_n low immediately clears regs[1..31], hi and lo to 0, independent of clk. While rst_n is low, writes are ignored. Reset values of all outputs are 0.
- GPR write: on a rising clk with rst_n high and reg_write_en=1:
  - if reg_write_addr≠0, regs[reg_write_addr] ← reg_write_data;
  - if reg_write_addr=0, no state changes.
- Read ports are combinational from addresses and state:
  - index 0 → 0x00000000 always;
  - otherwise regs[index];
  - write-through bypass: if reg_write_en=1, reg_write_addr≠0, and read address equals reg_write_addr, output reg_write_data in the same cycle. This serves the same-cycle WB→ID case.
  - Bypass is suppressed while rst_n is low; outputs read 0 then.
- HI/LO: independent enables; both may be written in the same edge (MULT/DIV). There is no bypass on hi_out/lo_out; they reflect the registered value only (MFHI after MTHI sees the new value one cycle later).
- register_v0 = regs[2], registered value, no bypass.
- Reading both ports with the same index returns identical values.
- X-safety: when reg_write_en=0, reg_write_addr and reg_write_data may be X without affecting any state or output.

## Timing

- Write latency: data presented at edge N is visible through state (no bypass) from just after edge N. It is visible via bypass during the cycle before edge N.
- Read latency: 0 cycles, combinational.
- Critical path: read address → 31:1 mux → bypass compare mux.
- Reset assertion mid-cycle clears state asynchronously. A write whose edge coincides with reset assertion is lost. First write honoured is on the first rising edge after rst_n deasserts.
- No stall or handshake. The block accepts one GPR write and one HI plus one LO write on every edge.

## Test plan

- Reset: preload regs[5]=0xDEADBEEF, hi=0x1, then pull rst_n low between edges. read_data_a (addr 5), hi_out and register_v0 must read 0 before the next edge.
- Link write: reg_write_en=1, addr=31, data=0xBFC00008. After the edge, read_addr_a=31 gives 0xBFC00008 and all other registers are unchanged.
- $0 protection: write 0x12345678 to addr 0. Both read ports at index 0 return 0, including during the write cycle (no bypass).
- Bypass: regs[8]=0xAAAA0000, then drive a write of 0x5555FFFF to addr 8 with read_addr_b=8 in the same cycle. read_data_b must be 0x5555FFFF before the edge and remain so after it.
- HI/LO: hi_write_en=lo_write_en=1 with 0x00000001/0xFFFFFFFE. hi_out/lo_out hold old values until the edge, then show the new ones. The GPRs are unaffected.
- Sweep: write i*0x01010101 to each of indices 1..31, then read all on both ports. Each returns its value, index 0 returns 0, and register_v0 = 0x02020202.
